// File: rtl/scandoubler_mode_ctrl.sv
// ----------------------------------------------------------------------------
// scandoubler_mode_ctrl
//
// Sequencer/configurator for the VGA scandoubler. Measures the native video
// timing (line period in clk28en ticks, lines per frame) and declares lock once
// the timing has been stable for LOCK_FRAMES consecutive frames. Requests for a
// mode change (15kHz/VGA) are applied only on frame boundaries. A switch made
// while locked blanks the output until the new mode has settled for
// MUTE_FRAMES frames.
//
// Optional feature: define SCANDBL_MODE_CTRL_STATUS_EN to add the status
// outputs hor_total (last measured line period) and frame_lines (line count of
// the last closed frame).
//
// Ports:
//   clk                 in   system clock
//   rst                 in   asynchronous reset, active high
//   clk28en             in   28 MHz clock enable; all state advances only on it
//   hsync_n             in   native hsync, active low
//   vsync_n             in   native vsync, active low
//   req_vga             in   requested mode: 1 = VGA scandoubled, 0 = 15kHz
//   req_scanlines       in   requested scanline effect
//   enable_scandoubling out  applied mode
//   disable_scaneffect  out  applied ~scanlines (updated every frame)
//   force_blank         out  1 = blank the video output
//   hor_total           out  [10:0] last line period (status build only)
//   frame_lines         out  [8:0] last frame's line count (status build only)
//   locked              out  1 = sequencer in LOCKED or MUTE
// ----------------------------------------------------------------------------
module scandoubler_mode_ctrl #(
    parameter int unsigned HTOL        = 8,
    parameter int unsigned LINES_MIN   = 262,
    parameter int unsigned LINES_MAX   = 320,
    parameter int unsigned LOCK_FRAMES = 4,
    parameter int unsigned MUTE_FRAMES = 2,
    parameter bit          RESET_VGA   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk28en,
    input  logic        hsync_n,
    input  logic        vsync_n,
    input  logic        req_vga,
    input  logic        req_scanlines,
    output logic        enable_scandoubling,
    output logic        disable_scaneffect,
    output logic        force_blank,
`ifdef SCANDBL_MODE_CTRL_STATUS_EN
    output logic [10:0] hor_total,
    output logic [8:0]  frame_lines,
`endif
    output logic        locked
);

    localparam logic [10:0] PeriodSat = 11'd2047;
    localparam logic [8:0]  LinesSat  = 9'd511;
    localparam logic [10:0] Htol      = 11'(HTOL);
    localparam logic [8:0]  LinesMin  = 9'(LINES_MIN);
    localparam logic [8:0]  LinesMax  = 9'(LINES_MAX);
    localparam logic [3:0]  LockCnt   = 4'(LOCK_FRAMES);
    localparam logic [3:0]  MuteCnt   = 4'(MUTE_FRAMES);

    typedef enum logic [1:0] {StUnlocked, StLocked, StArm, StMute} state_e;

    state_e      state_q, state_d;
    logic        hs_prev_q, vs_prev_q;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic [10:0] last_period_q, last_period_d;
    logic [8:0]  lines_q, lines_d;
    logic [8:0]  prev_lines_q, prev_lines_d;
    logic        stable_q, stable_d;
    logic [3:0]  valid_cnt_q, valid_cnt_d;
    logic [3:0]  mute_cnt_q, mute_cnt_d;
    logic        mode_q, mode_d;
    logic        noscan_q, noscan_d;
    logic        blank_q, blank_d;
    logic        locked_q, locked_d;

    logic        hs_fall, vs_fall;
    logic [10:0] period_diff;
    logic        line_stable;
    logic [8:0]  lines_incl;
    logic        stable_incl;
    logic        frame_valid;

    // ------------------------------------------------------------------------
    // Timing measurement
    // ------------------------------------------------------------------------
    always_comb begin
        hs_fall = clk28en & hs_prev_q & ~hsync_n;
        vs_fall = clk28en & vs_prev_q & ~vsync_n;

        period_diff = (line_cnt_q >= last_period_q) ? (line_cnt_q - last_period_q)
                                                    : (last_period_q - line_cnt_q);
        // A saturated counter means the real period is unknown.
        line_stable = (line_cnt_q != PeriodSat) && (period_diff <= Htol);

        // Line closed on this tick is counted before the frame is judged.
        lines_incl  = (hs_fall && (lines_q != LinesSat)) ? (lines_q + 9'd1) : lines_q;
        stable_incl = stable_q & (~hs_fall | line_stable);

        frame_valid = stable_incl && (lines_incl >= LinesMin) && (lines_incl <= LinesMax) &&
                      (lines_incl == prev_lines_q);

        line_cnt_d    = line_cnt_q;
        last_period_d = last_period_q;
        lines_d       = lines_q;
        prev_lines_d  = prev_lines_q;
        stable_d      = stable_q;
        valid_cnt_d   = valid_cnt_q;

        if (clk28en) begin
            if (hs_fall) begin
                line_cnt_d    = 11'd1;
                last_period_d = line_cnt_q;
            end else if (line_cnt_q != PeriodSat) begin
                line_cnt_d = line_cnt_q + 11'd1;
            end
            lines_d  = lines_incl;
            stable_d = stable_incl;
            if (vs_fall) begin
                lines_d      = '0;
                stable_d     = 1'b1;
                prev_lines_d = lines_incl;
                if (!frame_valid) begin
                    valid_cnt_d = '0;
                end else if (valid_cnt_q < LockCnt) begin
                    valid_cnt_d = valid_cnt_q + 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Mode sequencer
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        mute_cnt_d = mute_cnt_q;
        noscan_d   = noscan_q;

        // Scanline setting is cosmetic only, so it follows every frame unmuted.
        if (vs_fall) begin
            noscan_d = ~req_scanlines;
        end

        if (clk28en) begin
            unique case (state_q)
                StUnlocked: begin
                    if (vs_fall) begin
                        mode_d = req_vga;
                        if (valid_cnt_d == LockCnt) begin
                            state_d = StLocked;
                        end
                    end
                end
                StLocked: begin
                    if (vs_fall && !frame_valid) begin
                        state_d = StUnlocked;
                    end else if (req_vga != mode_q) begin
                        state_d = StArm;
                    end
                end
                StArm: begin
                    if (vs_fall) begin
                        mode_d     = req_vga;
                        mute_cnt_d = '0;
                        state_d    = frame_valid ? StMute : StUnlocked;
                    end
                end
                StMute: begin
                    if (vs_fall) begin
                        if (!frame_valid) begin
                            state_d = StUnlocked;
                        end else begin
                            mute_cnt_d = mute_cnt_q + 4'd1;
                            if ((mute_cnt_q + 4'd1) >= MuteCnt) begin
                                state_d = StLocked;
                            end
                        end
                    end
                end
                default: state_d = StUnlocked;
            endcase
        end

        // Outputs are registered from the next state so they track it exactly.
        blank_d  = (state_d == StArm) || (state_d == StMute);
        locked_d = (state_d == StLocked) || (state_d == StMute);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StUnlocked;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            line_cnt_q    <= '0;
            last_period_q <= '0;
            lines_q       <= '0;
            prev_lines_q  <= '0;
            stable_q      <= 1'b0;
            valid_cnt_q   <= '0;
            mute_cnt_q    <= '0;
            mode_q        <= RESET_VGA;
            noscan_q      <= 1'b0;
            blank_q       <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            if (clk28en) begin
                hs_prev_q <= hsync_n;
                vs_prev_q <= vsync_n;
            end
            state_q       <= state_d;
            line_cnt_q    <= line_cnt_d;
            last_period_q <= last_period_d;
            lines_q       <= lines_d;
            prev_lines_q  <= prev_lines_d;
            stable_q      <= stable_d;
            valid_cnt_q   <= valid_cnt_d;
            mute_cnt_q    <= mute_cnt_d;
            mode_q        <= mode_d;
            noscan_q      <= noscan_d;
            blank_q       <= blank_d;
            locked_q      <= locked_d;
        end
    end

    assign enable_scandoubling = mode_q;
    assign disable_scaneffect  = noscan_q;
    assign force_blank         = blank_q;
    assign locked              = locked_q;

`ifdef SCANDBL_MODE_CTRL_STATUS_EN
    logic [10:0] hor_total_q;
    logic [8:0]  frame_lines_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hor_total_q   <= '0;
            frame_lines_q <= '0;
        end else begin
            if (hs_fall) begin
                hor_total_q <= line_cnt_q;
            end
            if (vs_fall) begin
                frame_lines_q <= lines_incl;
            end
        end
    end

    assign hor_total   = hor_total_q;
    assign frame_lines = frame_lines_q;
`endif

endmodule

// File: tb/tb_scandoubler_mode_ctrl.sv
// Directed bench for scandoubler_mode_ctrl. Timing is scaled down (40-tick
// lines, 8..12 valid lines per frame) so full lock/switch sequences stay short.
// Each line ends with its hsync fall; a frame's last line also drops vsync on
// that same tick, so every frame close exercises the same-tick hsync/vsync case.
module tb_scandoubler_mode_ctrl;

    localparam int Per = 40;

    logic clk = 1'b0;
    logic rst, clk28en, hsync_n, vsync_n, req_vga, req_scanlines;
    logic enable_scandoubling, disable_scaneffect, force_blank, locked;
`ifdef SCANDBL_MODE_CTRL_STATUS_EN
    logic [10:0] hor_total;
    logic [8:0]  frame_lines;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scandoubler_mode_ctrl #(
        .HTOL        (8),
        .LINES_MIN   (8),
        .LINES_MAX   (12),
        .LOCK_FRAMES (4),
        .MUTE_FRAMES (2),
        .RESET_VGA   (1'b1)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .clk28en             (clk28en),
        .hsync_n             (hsync_n),
        .vsync_n             (vsync_n),
        .req_vga             (req_vga),
        .req_scanlines       (req_scanlines),
        .enable_scandoubling (enable_scandoubling),
        .disable_scaneffect  (disable_scaneffect),
        .force_blank         (force_blank),
`ifdef SCANDBL_MODE_CTRL_STATUS_EN
        .hor_total           (hor_total),
        .frame_lines         (frame_lines),
`endif
        .locked              (locked)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clk28en tick; outputs are sampled 1 time unit after the edge.
    task automatic tick(input logic hs, input logic vs);
        hsync_n = hs;
        vsync_n = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) tick(1'b1, 1'b1);
    endtask

    task automatic send_line(input int p, input bit close);
        run_ticks(p - 1);
        tick(1'b0, !close);
    endtask

    task automatic frame(input int n, input int odd_idx, input int odd_p);
        for (int l = 0; l < n; l++) begin
            send_line((l == odd_idx) ? odd_p : Per, l == n - 1);
        end
    endtask

    initial begin
        rst           = 1'b1;
        clk28en       = 1'b1;
        hsync_n       = 1'b1;
        vsync_n       = 1'b1;
        req_vga       = 1'b1;
        req_scanlines = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mode", enable_scandoubling, 1);
        check("rst_noscan", disable_scaneffect, 0);
        check("rst_blank", force_blank, 0);
        check("rst_locked", locked, 0);
        rst = 1'b0;

        // First close is invalid (stability flag clear), then four valid frames.
        for (int f = 1; f <= 5; f++) begin
            frame(10, -1, 0);
            if (f == 4) check("lock_not_yet", locked, 0);
        end
        check("lock_after5", locked, 1);
        check("lock_mode", enable_scandoubling, 1);
        check("lock_blank", force_blank, 0);

        // Mode switch 1 -> 0 mid-frame.
        for (int l = 0; l < 3; l++) send_line(Per, 0);
        req_vga = 1'b0;
        run_ticks(1);
        check("arm_blank", force_blank, 1);
        check("arm_mode_held", enable_scandoubling, 1);
        check("arm_locked", locked, 0);
        run_ticks(Per - 2);
        tick(1'b0, 1'b1);
        for (int l = 0; l < 5; l++) send_line(Per, 0);
        send_line(Per, 1);
        check("sw_mode", enable_scandoubling, 0);
        check("sw_blank", force_blank, 1);
        check("sw_locked", locked, 1);
        frame(10, -1, 0);
        check("mute1_blank", force_blank, 1);
        frame(10, -1, 0);
        check("mute_done_blank", force_blank, 0);
        check("mute_done_locked", locked, 1);
        check("mute_done_mode", enable_scandoubling, 0);

        // Line period tolerance: +8 is stable, +9 is not.
        frame(10, 4, Per + 8);
        check("htol_edge_locked", locked, 1);
        frame(10, 4, Per + 9);
        check("htol_over_locked", locked, 0);
        check("htol_over_blank", force_blank, 0);
        for (int f = 1; f <= 4; f++) begin
            frame(10, -1, 0);
            if (f == 3) check("relock_not_yet", locked, 0);
        end
        check("relock", locked, 1);

        // Invalid line counts; unlocked mode follows request every frame.
        frame(6, -1, 0);
        check("short_unlock", locked, 0);
        req_vga = 1'b1;
        frame(6, -1, 0);
        check("unl_mode1", enable_scandoubling, 1);
        check("unl_blank", force_blank, 0);
        req_vga = 1'b0;
        frame(11, -1, 0);
        check("unl_mode0", enable_scandoubling, 0);
        req_vga = 1'b1;
        frame(10, -1, 0);
        check("unl_mode1b", enable_scandoubling, 1);
        frame(11, -1, 0);
        frame(10, -1, 0);
        check("alt_no_lock", locked, 0);
        for (int f = 0; f < 5; f++) frame(13, -1, 0);
        check("long_no_lock", locked, 0);
        for (int f = 1; f <= 5; f++) begin
            frame(12, -1, 0);
            if (f == 4) check("max_not_yet", locked, 0);
        end
        check("max_lock", locked, 1);
        check("max_mode", enable_scandoubling, 1);

        // Scanline request: applied at frame close, no blanking.
        for (int l = 0; l < 12; l++) begin
            if (l == 3) req_scanlines = 1'b0;
            send_line(Per, l == 11);
            if (l == 5) check("scan_mid", disable_scaneffect, 0);
        end
        check("scan_applied", disable_scaneffect, 1);
        check("scan_blank", force_blank, 0);
        check("scan_locked", locked, 1);

        // clk28en low: inputs ignored, nothing advances.
        send_line(Per, 0);
        send_line(Per, 0);
        run_ticks(10);
        clk28en = 1'b0;
        req_vga = 1'b0;
        hsync_n = 1'b0;
        vsync_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("hold_blank", force_blank, 0);
        check("hold_mode", enable_scandoubling, 1);
        hsync_n = 1'b1;
        vsync_n = 1'b1;
        req_vga = 1'b1;
        clk28en = 1'b1;
        run_ticks(Per - 11);
        tick(1'b0, 1'b1);
        for (int l = 3; l < 12; l++) send_line(Per, l == 11);
        check("hold_frame_locked", locked, 1);

        // Reset asserted during MUTE takes effect without a clock edge.
        req_vga = 1'b0;
        frame(12, -1, 0);
        check("pre_rst_blank", force_blank, 1);
        check("pre_rst_mode", enable_scandoubling, 0);
        run_ticks(5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mode", enable_scandoubling, 1);
        check("arst_blank", force_blank, 0);
        check("arst_locked", locked, 0);
        check("arst_noscan", disable_scaneffect, 0);
        @(posedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
